usb_rx_packet_buffer: RTL and testbench

Parametrised USB bulk-endpoint receive packet buffer between the RX shift/decode logic and the AHB-Lite slave. It checks SYNC and PID, classifies packets, and CRC16-checks DATA0/DATA1 payloads. Payload bytes are staged in a transactional FIFO, so only CRC-clean, in-bounds packets become visible to the reader; errored packets are rolled back.

---
 rtl/usb_rx_packet_buffer.sv | 227 ++++++++++++++++++++++
 tb/tb_usb_rx_packet_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_buffer.sv
// USB bulk-endpoint receive buffer: SYNC/PID checking, packet classification, CRC16 on data
// payloads, and a transactional FIFO that only exposes CRC-clean, in-bounds packets to the reader.
module usb_rx_packet_buffer #(
    parameter int         FIFO_DEPTH   = 128,
    parameter int         MAX_PAYLOAD  = 64,
    parameter logic [7:0] SYNC_PATTERN = 8'b0000_0001
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           byte_complete,
    input  logic [7:0]                     packet_data,
    input  logic                           check_sync,
    input  logic                           check_pid,
    input  logic                           load_pid,
    input  logic                           load_data,
    input  logic                           load_error,
    input  logic                           load_done,
    input  logic                           flush,
    input  logic                           rd_en,
    output logic [1:0]                     sync_status,
    output logic [1:0]                     pid_status,
    output logic [7:0]                     pid,
    output logic [2:0]                     rx_packet,
    output logic                           data_toggle,
    output logic [$clog2(MAX_PAYLOAD):0]   payload_len,
    output logic                           packet_ready,
    output logic [7:0]                     rd_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(FIFO_DEPTH):0]    count,
    output logic                           overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_PAYLOAD) + 1;

    localparam logic [2:0] PKT_IDLE  = 3'b000;
    localparam logic [2:0] PKT_IN    = 3'b001;
    localparam logic [2:0] PKT_OUT   = 3'b010;
    localparam logic [2:0] PKT_ACK   = 3'b011;
    localparam logic [2:0] PKT_ERROR = 3'b100;
    localparam logic [2:0] PKT_DONE  = 3'b101;
    localparam logic [2:0] PKT_NACK  = 3'b110;
    localparam logic [2:0] PKT_DATA  = 3'b111;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'hB001;
    localparam logic [LW:0] RX_LIMIT     = (LW + 1)'(MAX_PAYLOAD + 2);
    localparam logic [LW:0] RX_MIN       = (LW + 1)'(2);
    localparam logic [AW:0] PTR_ONE      = (AW + 1)'(1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   wr_spec;
    logic [AW:0]   rd_ptr;
    logic [7:0]    skid0;
    logic [7:0]    skid1;
    logic [1:0]    skid_cnt;
    logic [15:0]   crc;
    logic [LW:0]   rx_cnt;
    logic [LW-1:0] spec_len;
    logic          len_err;
    logic          pkt_ovf;

    logic          pid_valid;
    logic          pkt_ctrl;
    logic          data_byte;
    logic          at_limit;
    logic          spec_full;
    logic          mem_we;
    logic          commit_ok;

    // Reflected CRC16 (poly 0xA001), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign pid_valid = (packet_data[7:4] == ~packet_data[3:0]);
    assign pkt_ctrl  = flush | load_error | load_done | (byte_complete & check_pid);
    assign data_byte = byte_complete & load_data & (rx_packet == PKT_DATA) & ~pkt_ctrl;
    assign at_limit  = (rx_cnt == RX_LIMIT);
    assign spec_full = (wr_spec[AW] != rd_ptr[AW]) && (wr_spec[AW-1:0] == rd_ptr[AW-1:0]);
    assign mem_we    = data_byte & ~at_limit & (skid_cnt == 2'd2) & ~spec_full;
    assign commit_ok = (crc == CRC_RESIDUAL) && (rx_cnt >= RX_MIN) && !len_err && !pkt_ovf;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // NOTE: the payload RAM has no reset; only pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_spec[AW-1:0]] <= skid0;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_status  <= 2'b00;
            pid_status   <= 2'b00;
            pid          <= 8'h00;
            rx_packet    <= PKT_IDLE;
            data_toggle  <= 1'b0;
            payload_len  <= '0;
            packet_ready <= 1'b0;
            overflow     <= 1'b0;
            wr_ptr       <= '0;
            wr_spec      <= '0;
            rd_ptr       <= '0;
            skid0        <= 8'h00;
            skid1        <= 8'h00;
            skid_cnt     <= 2'd0;
            crc          <= CRC_INIT;
            rx_cnt       <= '0;
            spec_len     <= '0;
            len_err      <= 1'b0;
            pkt_ovf      <= 1'b0;
        end else begin
            sync_status  <= 2'b00;
            pid_status   <= 2'b00;
            packet_ready <= 1'b0;

            if (byte_complete && check_sync) begin
                sync_status <= (packet_data == SYNC_PATTERN) ? 2'b01 : 2'b10;
            end
            if (byte_complete && load_pid) begin
                pid <= packet_data;
            end
            if (byte_complete && check_pid) begin
                pid_status <= pid_valid ? 2'b01 : 2'b10;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (flush) begin
                wr_ptr    <= '0;
                wr_spec   <= '0;
                rd_ptr    <= '0;
                skid_cnt  <= 2'd0;
                overflow  <= 1'b0;
                pkt_ovf   <= 1'b0;
                len_err   <= 1'b0;
                rx_cnt    <= '0;
                spec_len  <= '0;
                rx_packet <= PKT_IDLE;
            end else if (load_error) begin
                wr_spec   <= wr_ptr;
                skid_cnt  <= 2'd0;
                rx_packet <= PKT_ERROR;
            end else if (load_done) begin
                skid_cnt <= 2'd0;
                if (rx_packet != PKT_DATA) begin
                    rx_packet <= PKT_DONE;
                end else if (commit_ok) begin
                    wr_ptr       <= wr_spec;
                    payload_len  <= spec_len;
                    packet_ready <= 1'b1;
                    rx_packet    <= PKT_DONE;
                end else begin
                    wr_spec   <= wr_ptr;
                    rx_packet <= PKT_ERROR;
                end
            end else if (byte_complete && check_pid) begin
                if (!pid_valid) begin
                    rx_packet <= PKT_ERROR;
                end else begin
                    case (packet_data[3:0])
                        4'b0001: rx_packet <= PKT_OUT;
                        4'b1001: rx_packet <= PKT_IN;
                        4'b0010: rx_packet <= PKT_ACK;
                        4'b1010: rx_packet <= PKT_NACK;
                        4'b0011, 4'b1011: begin
                            rx_packet   <= PKT_DATA;
                            data_toggle <= packet_data[3];
                            crc         <= CRC_INIT;
                            skid_cnt    <= 2'd0;
                            rx_cnt      <= '0;
                            spec_len    <= '0;
                            len_err     <= 1'b0;
                            pkt_ovf     <= 1'b0;
                            wr_spec     <= wr_ptr;
                        end
                        default: rx_packet <= PKT_ERROR;
                    endcase
                end
            end else if (data_byte) begin
                crc <= crc16_byte(crc, packet_data);
                if (at_limit) begin
                    len_err <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + (LW + 1)'(1);
                    case (skid_cnt)
                        2'd0: begin
                            skid0    <= packet_data;
                            skid_cnt <= 2'd1;
                        end
                        2'd1: begin
                            skid1    <= packet_data;
                            skid_cnt <= 2'd2;
                        end
                        default: begin
                            // The oldest skid byte is known not to be CRC once a third byte arrives.
                            if (spec_full) begin
                                overflow <= 1'b1;
                                pkt_ovf  <= 1'b1;
                            end else begin
                                wr_spec  <= wr_spec + PTR_ONE;
                                spec_len <= spec_len + LW'(1);
                            end
                            skid0 <= skid1;
                            skid1 <= packet_data;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Directed bench for usb_rx_packet_buffer: status strobes, classification, commit/rollback,
// length error, overflow and flush, each scenario checked inline against hand-derived values.
module tb_usb_rx_packet_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_complete, check_sync, check_pid, load_pid, load_data;
    logic       load_error, load_done, flush, rd_en;
    logic [7:0] packet_data;
    logic [1:0] sync_status, pid_status;
    logic [7:0] pid;
    logic [2:0] rx_packet;
    logic       data_toggle;
    logic [6:0] payload_len;
    logic       packet_ready;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [7:0] count;
    logic       overflow;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] pl[$];

    always #5 clk = ~clk;

    usb_rx_packet_buffer #(
        .FIFO_DEPTH(128), .MAX_PAYLOAD(64), .SYNC_PATTERN(8'h01)
    ) dut (
        .clk(clk), .rst(rst), .byte_complete(byte_complete), .packet_data(packet_data),
        .check_sync(check_sync), .check_pid(check_pid), .load_pid(load_pid),
        .load_data(load_data), .load_error(load_error), .load_done(load_done),
        .flush(flush), .rd_en(rd_en), .sync_status(sync_status), .pid_status(pid_status),
        .pid(pid), .rx_packet(rx_packet), .data_toggle(data_toggle),
        .payload_len(payload_len), .packet_ready(packet_ready), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // q = {check_sync, check_pid, load_pid, load_data}; returns at the negedge after capture.
    task automatic byte_in(input logic [7:0] d, input logic [3:0] q);
        @(negedge clk);
        packet_data   = d;
        byte_complete = 1'b1;
        {check_sync, check_pid, load_pid, load_data} = q;
        @(negedge clk);
        byte_complete = 1'b0;
        {check_sync, check_pid, load_pid, load_data} = 4'b0000;
    endtask

    task automatic done_in(input logic with_rd);
        @(negedge clk);
        load_done = 1'b1;
        rd_en     = with_rd;
        @(negedge clk);
        load_done = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic read_one;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_flush;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Sends PID, payload from pl, then the complemented CRC (low byte first); no close.
    task automatic send_data_pkt(input logic [7:0] pid_b, input logic bad_crc);
        logic [15:0] c;
        c = 16'hFFFF;
        byte_in(pid_b, 4'b0110);
        foreach (pl[i]) begin
            c = crc16(c, pl[i]);
            byte_in(pl[i], 4'b0001);
        end
        c = ~c;
        byte_in(c[7:0] ^ (bad_crc ? 8'h01 : 8'h00), 4'b0001);
        byte_in(c[15:8], 4'b0001);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {byte_complete, check_sync, check_pid, load_pid, load_data} = '0;
        {load_error, load_done, flush, rd_en} = '0;
        packet_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (rx_packet !== 3'b000) begin fails++; $display("FAIL reset_rx_packet got=%b exp=000", rx_packet); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests++; if ({sync_status, pid_status, pid, data_toggle, payload_len, packet_ready} !== '0) begin
            fails++; $display("FAIL reset_status got=%h exp=0", {sync_status, pid_status, pid, data_toggle, payload_len, packet_ready}); end
        tests++; if ({full, count, overflow, rd_data} !== '0) begin
            fails++; $display("FAIL reset_fifo got=%h exp=0", {full, count, overflow, rd_data}); end
    endtask

    task automatic test_sync;
        byte_in(8'h01, 4'b1000);
        tests++; if (sync_status !== 2'b01) begin fails++; $display("FAIL sync_ok got=%b exp=01", sync_status); end
        @(negedge clk);
        tests++; if (sync_status !== 2'b00) begin fails++; $display("FAIL sync_ok_clear got=%b exp=00", sync_status); end
        byte_in(8'h80, 4'b1000);
        tests++; if (sync_status !== 2'b10) begin fails++; $display("FAIL sync_bad got=%b exp=10", sync_status); end
        @(negedge clk);
        tests++; if (sync_status !== 2'b00) begin fails++; $display("FAIL sync_bad_clear got=%b exp=00", sync_status); end
    endtask

    task automatic test_pid;
        byte_in(8'h69, 4'b0110);
        tests++; if (pid_status !== 2'b01) begin fails++; $display("FAIL pid_in_status got=%b exp=01", pid_status); end
        tests++; if (pid !== 8'h69) begin fails++; $display("FAIL pid_in_value got=%h exp=69", pid); end
        tests++; if (rx_packet !== 3'b001) begin fails++; $display("FAIL pid_in_class got=%b exp=001", rx_packet); end
        @(negedge clk);
        tests++; if (pid_status !== 2'b00) begin fails++; $display("FAIL pid_status_clear got=%b exp=00", pid_status); end
        byte_in(8'h6A, 4'b0110);
        tests++; if (pid_status !== 2'b10) begin fails++; $display("FAIL pid_bad_status got=%b exp=10", pid_status); end
        tests++; if (rx_packet !== 3'b100) begin fails++; $display("FAIL pid_bad_class got=%b exp=100", rx_packet); end
        done_in(1'b0);
        tests++; if (rx_packet !== 3'b101) begin fails++; $display("FAIL pid_nondata_done got=%b exp=101", rx_packet); end
    endtask

    task automatic test_data_commit;
        logic [7:0] exp_b;
        pl = '{8'h01, 8'h02, 8'h03};
        send_data_pkt(8'hC3, 1'b0);
        tests++; if (rx_packet !== 3'b111) begin fails++; $display("FAIL data_class got=%b exp=111", rx_packet); end
        done_in(1'b0);
        tests++; if (packet_ready !== 1'b1) begin fails++; $display("FAIL commit_ready got=%b exp=1", packet_ready); end
        tests++; if (count !== 8'd3) begin fails++; $display("FAIL commit_count got=%0d exp=3", count); end
        tests++; if (payload_len !== 7'd3) begin fails++; $display("FAIL commit_len got=%0d exp=3", payload_len); end
        tests++; if (rx_packet !== 3'b101 || data_toggle !== 1'b0) begin
            fails++; $display("FAIL commit_state got=%b/%b exp=101/0", rx_packet, data_toggle); end
        @(negedge clk);
        tests++; if (packet_ready !== 1'b0) begin fails++; $display("FAIL commit_ready_pulse got=%b exp=0", packet_ready); end
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'(i + 1);
            tests++; if (rd_data !== exp_b) begin fails++; $display("FAIL read_seq[%0d] got=%h exp=%h", i, rd_data, exp_b); end
            read_one();
        end
        tests++; if (empty !== 1'b1 || count !== 8'd0) begin
            fails++; $display("FAIL read_drained got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_bad_crc;
        pl = '{8'h01, 8'h02, 8'h03};
        send_data_pkt(8'h4B, 1'b1);
        tests++; if (data_toggle !== 1'b1) begin fails++; $display("FAIL data1_toggle got=%b exp=1", data_toggle); end
        done_in(1'b0);
        tests++; if (rx_packet !== 3'b100) begin fails++; $display("FAIL badcrc_class got=%b exp=100", rx_packet); end
        tests++; if (packet_ready !== 1'b0 || count !== 8'd0) begin
            fails++; $display("FAIL badcrc_fifo got=%b/%0d exp=0/0", packet_ready, count); end
    endtask

    task automatic test_load_error;
        pl = '{8'h55, 8'h66, 8'h77};
        send_data_pkt(8'hC3, 1'b0);
        @(negedge clk);
        load_error = 1'b1;
        load_done  = 1'b1;
        @(negedge clk);
        load_error = 1'b0;
        load_done  = 1'b0;
        tests++; if (rx_packet !== 3'b100 || count !== 8'd0 || packet_ready !== 1'b0) begin
            fails++; $display("FAIL load_error got=%b/%0d/%b exp=100/0/0", rx_packet, count, packet_ready); end
    endtask

    task automatic test_too_long;
        pl = '{8'hAA, 8'hBB};
        send_data_pkt(8'hC3, 1'b0);
        done_in(1'b0);
        tests++; if (count !== 8'd2) begin fails++; $display("FAIL prior_commit got=%0d exp=2", count); end
        pl.delete();
        for (int i = 0; i < 65; i++) pl.push_back(8'(i + 16));
        send_data_pkt(8'h4B, 1'b0);
        done_in(1'b0);
        tests++; if (rx_packet !== 3'b100 || packet_ready !== 1'b0) begin
            fails++; $display("FAIL too_long_class got=%b/%b exp=100/0", rx_packet, packet_ready); end
        tests++; if (count !== 8'd2 || payload_len !== 7'd2) begin
            fails++; $display("FAIL too_long_rollback got=%0d/%0d exp=2/2", count, payload_len); end
        tests++; if (rd_data !== 8'hAA) begin fails++; $display("FAIL too_long_head got=%h exp=aa", rd_data); end
        read_one();
        tests++; if (rd_data !== 8'hBB) begin fails++; $display("FAIL too_long_second got=%h exp=bb", rd_data); end
        read_one();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL too_long_drained got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back;
        pl = '{8'h11, 8'h22};
        send_data_pkt(8'hC3, 1'b0);
        done_in(1'b0);
        pl = '{8'h33};
        send_data_pkt(8'h4B, 1'b0);
        done_in(1'b1);
        tests++; if (count !== 8'd2 || payload_len !== 7'd1) begin
            fails++; $display("FAIL commit_with_read got=%0d/%0d exp=2/1", count, payload_len); end
        tests++; if (rd_data !== 8'h22) begin fails++; $display("FAIL commit_with_read_head got=%h exp=22", rd_data); end
        read_one();
        read_one();
        read_one();
        tests++; if (empty !== 1'b1 || count !== 8'd0) begin
            fails++; $display("FAIL read_when_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_overflow;
        pl.delete();
        for (int i = 0; i < 63; i++) pl.push_back(8'(i));
        for (int k = 0; k < 2; k++) begin
            send_data_pkt(8'hC3, 1'b0);
            done_in(1'b0);
            tests++; if (packet_ready !== 1'b1 || payload_len !== 7'd63) begin
                fails++; $display("FAIL fill_commit[%0d] got=%b/%0d exp=1/63", k, packet_ready, payload_len); end
        end
        tests++; if (count !== 8'd126 || full !== 1'b0) begin
            fails++; $display("FAIL fill_count got=%0d/%b exp=126/0", count, full); end
        pl = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send_data_pkt(8'hC3, 1'b0);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
        done_in(1'b0);
        tests++; if (rx_packet !== 3'b100 || count !== 8'd126 || packet_ready !== 1'b0) begin
            fails++; $display("FAIL overflow_rollback got=%b/%0d/%b exp=100/126/0", rx_packet, count, packet_ready); end
        tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL overflow_head got=%h exp=00", rd_data); end
        do_flush();
        tests++; if (count !== 8'd0 || overflow !== 1'b0 || rx_packet !== 3'b000 || empty !== 1'b1) begin
            fails++; $display("FAIL flush got=%0d/%b/%b/%b exp=0/0/000/1", count, overflow, rx_packet, empty); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_pid();
        test_data_commit();
        test_bad_crc();
        test_load_error();
        test_too_long();
        test_back_to_back();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
